// File: rtl/color_frame_classifier.sv
// rtl/color_frame_classifier.sv - dominant-colour classifier with debounced one-hot LED and frame timeout
`timescale 1ns/1ps
module color_frame_classifier #(
    parameter int unsigned    PW       = 16,
    parameter logic [PW-1:0]  DARK_THR = 16'd6000,
    parameter logic [PW-1:0]  MARGIN   = 16'd300,
    parameter int unsigned    AGREE    = 3,
    parameter logic [19:0]    TIMEOUT  = 20'd500000
) (
    input  logic          clk_50,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] r_period,
    input  logic [PW-1:0] g_period,
    input  logic [PW-1:0] b_period,
    output logic [2:0]    led,
    output logic [1:0]    color_code,
    output logic          stable,
    output logic          class_valid
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLASSIFY = 2'd1;
    localparam logic [1:0] ST_UPDATE   = 2'd2;

    localparam logic [1:0] C_NONE  = 2'd0;
    localparam logic [1:0] C_RED   = 2'd1;
    localparam logic [1:0] C_GREEN = 2'd2;
    localparam logic [1:0] C_BLUE  = 2'd3;

    localparam logic [3:0] AGREE_C = 4'(AGREE);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic [1:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [19:0]   to_q, to_d;
    logic [1:0]    code_q, code_d;
    logic [2:0]    led_q, led_d;
    logic          stable_q, stable_d;

    logic [PW-1:0] min_p, second_p;
    logic [1:0]    min_ch, raw;
    logic          accept;

    function automatic logic [2:0] led_of(input logic [1:0] code);
        case (code)
            C_RED:   led_of = 3'b100;
            C_GREEN: led_of = 3'b010;
            C_BLUE:  led_of = 3'b001;
            default: led_of = 3'b000;
        endcase
    endfunction

    assign in_ready    = (state_q == ST_IDLE);
    assign class_valid = (state_q == ST_UPDATE);
    assign accept      = in_valid && in_ready;
    assign led         = led_q;
    assign color_code  = code_q;
    assign stable      = stable_q;

    // Smallest period wins; ties resolve red, then green, then blue.
    always_comb begin
        min_p    = r_q;
        second_p = (g_q < b_q) ? g_q : b_q;
        min_ch   = C_RED;
        if (!(r_q <= g_q && r_q <= b_q)) begin
            if (g_q <= b_q) begin
                min_p    = g_q;
                second_p = (r_q < b_q) ? r_q : b_q;
                min_ch   = C_GREEN;
            end else begin
                min_p    = b_q;
                second_p = (r_q < g_q) ? r_q : g_q;
                min_ch   = C_BLUE;
            end
        end
        if (min_p > DARK_THR)
            raw = C_NONE;
        else if ((second_p - min_p) < MARGIN)
            raw = C_NONE;
        else
            raw = min_ch;
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        led_d    = led_q;
        stable_d = stable_q;
        to_d     = to_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    r_d     = r_period;
                    g_d     = g_period;
                    b_d     = b_period;
                    state_d = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                // Debounce result is registered here so led and the class_valid pulse appear together in UPDATE.
                if (raw == cand_q) begin
                    cnt_d = (cnt_q >= AGREE_C) ? AGREE_C : cnt_q + 4'd1;
                end else begin
                    cand_d = raw;
                    cnt_d  = 4'd1;
                end
                if (cnt_d == AGREE_C) begin
                    code_d   = cand_d;
                    led_d    = led_of(cand_d);
                    stable_d = 1'b1;
                end
                state_d = ST_UPDATE;
            end
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (accept) begin
            to_d = 20'd0;
        end else if (to_q != TIMEOUT) begin
            to_d = to_q + 20'd1;
            if (to_d == TIMEOUT) begin
                code_d   = C_NONE;
                led_d    = 3'b000;
                stable_d = 1'b0;
                cand_d   = C_NONE;
                cnt_d    = 4'd0;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            cand_q   <= C_NONE;
            cnt_q    <= 4'd0;
            to_q     <= 20'd0;
            code_q   <= C_NONE;
            led_q    <= 3'b000;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            code_q   <= code_d;
            led_q    <= led_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: tb/tb_color_frame_classifier.sv
// tb/tb_color_frame_classifier.sv - directed vector bench for color_frame_classifier
`timescale 1ns/1ps
module tb_color_frame_classifier;

    localparam logic [19:0] TO = 20'd40;

    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] r_period, g_period, b_period;
    logic [2:0]  led;
    logic [1:0]  color_code;
    logic        stable;
    logic        class_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] r, g, b;
        logic [2:0]  led;
        logic [1:0]  code;
        logic        stable;
    } vec_t;

    vec_t vecs[21];

    color_frame_classifier #(.TIMEOUT(TO)) dut (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .r_period    (r_period),
        .g_period    (g_period),
        .b_period    (b_period),
        .led         (led),
        .color_code  (color_code),
        .stable      (stable),
        .class_valid (class_valid)
    );

    always #5 clk_50 = ~clk_50;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] el, input logic [1:0] ec, input logic es);
        chk({tag, ".led"}, 32'(led), 32'(el));
        chk({tag, ".code"}, 32'(color_code), 32'(ec));
        chk({tag, ".stable"}, 32'(stable), 32'(es));
    endtask

    // Called at a negedge; returns at the negedge of the UPDATE cycle.
    task automatic send(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                        input logic [2:0] el, input logic [1:0] ec, input logic es, input string tag);
        int w;
        r_period = r;
        g_period = g;
        b_period = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 10) begin
            @(negedge clk_50);
            w++;
        end
        chk({tag, ".ready_wait"}, 32'(in_ready), 32'd1);
        @(posedge clk_50);
        #1 in_valid = 1'b0;
        @(negedge clk_50);
        chk({tag, ".cls_ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".cls_valid"}, 32'(class_valid), 32'd0);
        @(negedge clk_50);
        chk({tag, ".upd_valid"}, 32'(class_valid), 32'd1);
        chk_out(tag, el, ec, es);
    endtask

    initial begin
        vecs[0]  = '{16'd5000, 16'd2700, 16'd4000, 3'b000, 2'd0, 1'b0};
        vecs[1]  = '{16'd5000, 16'd2700, 16'd4000, 3'b000, 2'd0, 1'b0};
        vecs[2]  = '{16'd5000, 16'd5000, 16'd2000, 3'b000, 2'd0, 1'b0};
        vecs[3]  = '{16'd5000, 16'd5000, 16'd2000, 3'b000, 2'd0, 1'b0};
        vecs[4]  = '{16'd5000, 16'd5000, 16'd2000, 3'b001, 2'd3, 1'b1};
        vecs[5]  = '{16'd5000, 16'd5000, 16'd2000, 3'b001, 2'd3, 1'b1};
        vecs[6]  = '{16'd2000, 16'd5000, 16'd6000, 3'b001, 2'd3, 1'b1};
        vecs[7]  = '{16'd2000, 16'd5000, 16'd6000, 3'b001, 2'd3, 1'b1};
        vecs[8]  = '{16'd2000, 16'd5000, 16'd6000, 3'b100, 2'd1, 1'b1};
        vecs[9]  = '{16'd2000, 16'd2200, 16'd6000, 3'b100, 2'd1, 1'b1};
        vecs[10] = '{16'd8000, 16'd8000, 16'd8000, 3'b100, 2'd1, 1'b1};
        vecs[11] = '{16'd2000, 16'd2000, 16'd6000, 3'b000, 2'd0, 1'b1};
        vecs[12] = '{16'd2000, 16'd2300, 16'd9000, 3'b000, 2'd0, 1'b1};
        vecs[13] = '{16'd2000, 16'd2300, 16'd9000, 3'b000, 2'd0, 1'b1};
        vecs[14] = '{16'd2000, 16'd2300, 16'd9000, 3'b100, 2'd1, 1'b1};
        vecs[15] = '{16'd7000, 16'd7000, 16'd6000, 3'b100, 2'd1, 1'b1};
        vecs[16] = '{16'd7000, 16'd7000, 16'd6000, 3'b100, 2'd1, 1'b1};
        vecs[17] = '{16'd7000, 16'd7000, 16'd6000, 3'b001, 2'd3, 1'b1};
        vecs[18] = '{16'd2000, 16'd5000, 16'd6000, 3'b001, 2'd3, 1'b1};
        vecs[19] = '{16'd2000, 16'd5000, 16'd6000, 3'b001, 2'd3, 1'b1};
        vecs[20] = '{16'd2000, 16'd5000, 16'd6000, 3'b100, 2'd1, 1'b1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        r_period = '0;
        g_period = '0;
        b_period = '0;
        repeat (3) @(negedge clk_50);
        chk_out("rst_hold", 3'b000, 2'd0, 1'b0);
        chk("rst_hold.ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk_50);
        chk_out("rst_rel", 3'b000, 2'd0, 1'b0);
        chk("rst_rel.ready", 32'(in_ready), 32'd1);
        chk("rst_rel.cv", 32'(class_valid), 32'd0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk_50);
            send(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].led, vecs[i].code, vecs[i].stable,
                 $sformatf("vec%0d", i));
        end

        // Timeout: last acceptance was 2 negedges ago; led clears exactly at count TO.
        repeat (TO - 2) @(negedge clk_50);
        chk_out("to_before", 3'b100, 2'd1, 1'b1);
        @(negedge clk_50);
        chk_out("to_hit", 3'b000, 2'd0, 1'b0);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50);
            send(16'd2000, 16'd5000, 16'd6000, (i == 2) ? 3'b100 : 3'b000,
                 (i == 2) ? 2'd1 : 2'd0, (i == 2), $sformatf("relock%0d", i));
        end
        repeat (TO - 2) @(negedge clk_50);
        send(16'd2000, 16'd5000, 16'd6000, 3'b100, 2'd1, 1'b1, "to_race");

        @(negedge clk_50);
        r_period = 16'd2000;
        g_period = 16'd5000;
        b_period = 16'd6000;
        in_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("bp%0d.ready", k), 32'(in_ready), (k % 3 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("bp%0d.cv", k), 32'(class_valid), (k % 3 == 2) ? 32'd1 : 32'd0);
            @(negedge clk_50);
        end
        chk("bp_accept.ready", 32'(in_ready), 32'd1);
        @(negedge clk_50);
        chk("mid.classify", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 3'b000, 2'd0, 1'b0);
        chk("mid_rst.cv", 32'(class_valid), 32'd0);
        chk("mid_rst.ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk_50);
            chk("mid_hold.cv", 32'(class_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk_50);
        chk("mid_rel.cv", 32'(class_valid), 32'd0);
        chk("mid_rel.ready", 32'(in_ready), 32'd1);
        chk_out("mid_rel", 3'b000, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
